// File: rtl/pid_seq_pkg.sv
// Shared types and helpers for the PID update sequencer: state encoding, default widths, saturation.
// Pure declarations; no timing or flow control of its own.
package pid_seq_pkg;

  localparam int DEF_W    = 19;
  localparam int DEF_FRAC = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROP  = 3'd1,
    INTEG = 3'd2,
    DERIV = 3'd3,
    SUM   = 3'd4
  } state_t;

  // Width-generic clamp helpers; callers sign-extend into 64 bits and pass the target width.
  function automatic logic sat_ovf(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (x > hi) || (x < lo);
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/pid_update_sequencer_if.sv
// Bundle of update request, operands and control results between the speed front end and the PWM side.
// Requests are single-cycle pulses with no backpressure; busy/ovr report when a request could not be taken.
interface pid_update_sequencer_if
  import pid_seq_pkg::*;
#(
  parameter int W = DEF_W
);
  logic                upd;
  logic                clr_int;
  logic signed [W-1:0] N_ref;
  logic signed [W-1:0] N_fb;
  logic signed [W-1:0] K_p;
  logic signed [W-1:0] K_i;
  logic signed [W-1:0] K_d;
  logic signed [W-1:0] N_con;
  logic                valid;
  logic                busy;
  logic                sat;
  logic                ovr;

  modport master (
    output upd, clr_int, N_ref, N_fb, K_p, K_i, K_d,
    input  N_con, valid, busy, sat, ovr
  );

  modport slave (
    input  upd, clr_int, N_ref, N_fb, K_p, K_i, K_d,
    output N_con, valid, busy, sat, ovr
  );
endinterface

// File: rtl/pid_sat_mul.sv
// Shared signed multiplier: a*b, arithmetic shift right by FRAC, clamp to W bits with overflow flag.
// Purely combinational, zero latency, no flow control.
module pid_sat_mul
  import pid_seq_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                ovf
);
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shr;

  assign prod = (2*W)'(a) * (2*W)'(b);
  assign shr  = prod >>> FRAC;
  assign ovf  = sat_ovf(64'(shr), W);
  assign y    = W'(sat_val(64'(shr), W));
endmodule

// File: rtl/pid_update_sequencer.sv
// One PID update per upd pulse over a single shared multiplier; N_con/valid land 4 cycles after upd.
// No backpressure: upd outside IDLE is dropped and latched into the sticky ovr flag.
module pid_update_sequencer
  import pid_seq_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                     f_pwm,
  input  logic                     rst,
  pid_update_sequencer_if.slave    bus
);
  state_t st;
  state_t st_nxt;

  logic signed [W-1:0] kp_r, ki_r, kd_r;
  logic signed [W-1:0] e_r, e_prev;
  logic signed [W-1:0] p_r, i_acc, d_r;
  logic signed [W-1:0] con_r;
  logic                valid_r, sat_r, sat_acc, ovr_r;

  logic signed [W-1:0] mul_a, mul_b, mul_y;
  logic                mul_ovf;

  logic signed [W:0]   e_raw, diff_raw, iacc_raw;
  logic signed [W+1:0] sum_raw;
  logic signed [W-1:0] e_new, diff, iacc_new, sum_new;
  logic                e_ovf, diff_ovf, iacc_ovf, sum_ovf;

  assign e_raw    = (W+1)'(bus.N_ref) - (W+1)'(bus.N_fb);
  assign e_new    = W'(sat_val(64'(e_raw), W));
  assign e_ovf    = sat_ovf(64'(e_raw), W);

  assign diff_raw = (W+1)'(e_r) - (W+1)'(e_prev);
  assign diff     = W'(sat_val(64'(diff_raw), W));
  assign diff_ovf = sat_ovf(64'(diff_raw), W);

  assign iacc_raw = (W+1)'(i_acc) + (W+1)'(mul_y);
  assign iacc_new = W'(sat_val(64'(iacc_raw), W));
  assign iacc_ovf = sat_ovf(64'(iacc_raw), W);

  assign sum_raw  = (W+2)'(p_r) + (W+2)'(i_acc) + (W+2)'(d_r);
  assign sum_new  = W'(sat_val(64'(sum_raw), W));
  assign sum_ovf  = sat_ovf(64'(sum_raw), W);

  pid_sat_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  always_ff @(posedge f_pwm or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // Operand mux follows the state so each stage reuses the one multiplier.
  always_comb begin
    st_nxt = st;
    mul_a  = '0;
    mul_b  = '0;
    case (st)
      IDLE:    if (bus.upd) st_nxt = PROP;
      PROP:    begin st_nxt = INTEG; mul_a = kp_r; mul_b = e_r;  end
      INTEG:   begin st_nxt = DERIV; mul_a = ki_r; mul_b = e_r;  end
      DERIV:   begin st_nxt = SUM;   mul_a = kd_r; mul_b = diff; end
      SUM:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge f_pwm or negedge rst) begin
    if (!rst) begin
      kp_r    <= '0;
      ki_r    <= '0;
      kd_r    <= '0;
      e_r     <= '0;
      e_prev  <= '0;
      p_r     <= '0;
      i_acc   <= '0;
      d_r     <= '0;
      con_r   <= '0;
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
      sat_acc <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (st != IDLE && bus.upd) ovr_r <= 1'b1;
      case (st)
        IDLE: begin
          // Clear lands on the acceptance edge, so a simultaneous update sees zeroed history.
          if (bus.clr_int) begin
            i_acc  <= '0;
            e_prev <= '0;
          end
          if (bus.upd) begin
            kp_r    <= bus.K_p;
            ki_r    <= bus.K_i;
            kd_r    <= bus.K_d;
            e_r     <= e_new;
            sat_acc <= e_ovf;
          end
        end
        PROP: begin
          p_r     <= mul_y;
          sat_acc <= sat_acc | mul_ovf;
        end
        INTEG: begin
          i_acc   <= iacc_new;
          sat_acc <= sat_acc | mul_ovf | iacc_ovf;
        end
        DERIV: begin
          d_r     <= mul_y;
          e_prev  <= e_r;
          sat_acc <= sat_acc | mul_ovf | diff_ovf;
        end
        SUM: begin
          con_r   <= sum_new;
          valid_r <= 1'b1;
          sat_r   <= sat_acc | sum_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.N_con = con_r;
  assign bus.valid = valid_r;
  assign bus.busy  = (st != IDLE);
  assign bus.sat   = sat_r;
  assign bus.ovr   = ovr_r;
endmodule

// File: tb/tb_pid_update_sequencer.sv
// Directed bench for pid_update_sequencer: hand-computed P/I/D results, saturation, overrun and reset cases.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_pid_update_sequencer;
  localparam int W = 19;

  logic f_pwm;
  logic rst;
  int   tests;
  int   fails;

  pid_update_sequencer_if #(.W(W)) bus ();

  pid_update_sequencer #(.W(W), .FRAC(2)) dut (
    .f_pwm (f_pwm),
    .rst   (rst),
    .bus   (bus)
  );

  initial f_pwm = 1'b0;
  always #5 f_pwm = ~f_pwm;

  task automatic do_reset;
    rst         = 1'b0;
    bus.upd     = 1'b0;
    bus.clr_int = 1'b0;
    bus.N_ref   = '0;
    bus.N_fb    = '0;
    bus.K_p     = '0;
    bus.K_i     = '0;
    bus.K_d     = '0;
    repeat (2) @(negedge f_pwm);
    rst = 1'b1;
    @(negedge f_pwm);
  endtask

  // Issue one update and wait (bounded) for valid; lat stays -1 if valid never arrives.
  task automatic issue_upd(input int nref, input int nfb, input int kp, input int ki, input int kd,
                           input logic clr, output int lat, output logic signed [W-1:0] con,
                           output logic s, output logic busy_k, output logic busy_end);
    @(negedge f_pwm);
    bus.N_ref   = W'(nref);
    bus.N_fb    = W'(nfb);
    bus.K_p     = W'(kp);
    bus.K_i     = W'(ki);
    bus.K_d     = W'(kd);
    bus.clr_int = clr;
    bus.upd     = 1'b1;
    @(negedge f_pwm);
    bus.upd     = 1'b0;
    bus.clr_int = 1'b0;
    busy_k      = bus.busy;
    lat         = -1;
    con         = '0;
    s           = 1'b0;
    busy_end    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge f_pwm);
      if (bus.valid) begin
        lat      = c;
        con      = bus.N_con;
        s        = bus.sat;
        busy_end = bus.busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    tests++; if (bus.N_con !== 19'sd0) begin fails++; $display("FAIL reset_ncon: got %0d expected 0", bus.N_con); end
    tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b expected 0", bus.sat); end
    tests++; if (bus.ovr !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b expected 0", bus.ovr); end
  endtask

  task automatic test_proportional;
    int lat; logic signed [W-1:0] con; logic s, bk, be;
    do_reset();
    issue_upd(100, 0, 320, 0, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (lat != 4) begin fails++; $display("FAIL prop_latency: got %0d expected 4", lat); end
    tests++; if (con !== 19'sd8000) begin fails++; $display("FAIL prop_ncon: got %0d expected 8000", con); end
    tests++; if (s !== 1'b0) begin fails++; $display("FAIL prop_sat: got %b expected 0", s); end
    tests++; if (bk !== 1'b1) begin fails++; $display("FAIL prop_busy_start: got %b expected 1", bk); end
    tests++; if (be !== 1'b0) begin fails++; $display("FAIL prop_busy_end: got %b expected 0", be); end
    @(negedge f_pwm);
    tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL prop_valid_width: got %b expected 0", bus.valid); end
    tests++; if (bus.N_con !== 19'sd8000) begin fails++; $display("FAIL prop_hold: got %0d expected 8000", bus.N_con); end
  endtask

  task automatic test_saturation;
    int lat; logic signed [W-1:0] con; logic s, bk, be;
    do_reset();
    issue_upd(16382, 0, 320, 0, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd262143) begin fails++; $display("FAIL sat_pos_ncon: got %0d expected 262143", con); end
    tests++; if (s !== 1'b1) begin fails++; $display("FAIL sat_pos_flag: got %b expected 1", s); end
    issue_upd(-16382, 0, 320, 0, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== -19'sd262144) begin fails++; $display("FAIL sat_neg_ncon: got %0d expected -262144", con); end
    tests++; if (s !== 1'b1) begin fails++; $display("FAIL sat_neg_flag: got %b expected 1", s); end
    issue_upd(100, 0, 320, 0, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd8000) begin fails++; $display("FAIL sat_clear_ncon: got %0d expected 8000", con); end
    tests++; if (s !== 1'b0) begin fails++; $display("FAIL sat_clear_flag: got %b expected 0", s); end
  endtask

  task automatic test_integral;
    int lat; logic signed [W-1:0] con; logic s, bk, be;
    int exp_v [3] = '{10, 20, 30};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      issue_upd(10, 0, 0, 4, 0, 1'b0, lat, con, s, bk, be);
      repeat (4) @(negedge f_pwm);
      tests++; if (con !== W'(exp_v[n])) begin fails++; $display("FAIL integ_step%0d: got %0d expected %0d", n, con, exp_v[n]); end
    end
    issue_upd(10, 0, 0, 4, 0, 1'b1, lat, con, s, bk, be);
    tests++; if (con !== 19'sd10) begin fails++; $display("FAIL integ_clear: got %0d expected 10", con); end
    tests++; if (lat != 4) begin fails++; $display("FAIL integ_clear_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_derivative;
    int lat; logic signed [W-1:0] con; logic s, bk, be;
    do_reset();
    issue_upd(10, 0, 0, 0, 4, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd10) begin fails++; $display("FAIL deriv_first: got %0d expected 10", con); end
    issue_upd(30, 0, 0, 0, 4, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd20) begin fails++; $display("FAIL deriv_second: got %0d expected 20", con); end
  endtask

  task automatic test_overrun;
    int nvalid; logic signed [W-1:0] got;
    do_reset();
    @(negedge f_pwm);
    bus.K_p = 19'sd320; bus.N_ref = 19'sd100; bus.N_fb = '0; bus.upd = 1'b1;
    @(negedge f_pwm); bus.upd = 1'b0;                 // after edge 0
    @(negedge f_pwm); bus.upd = 1'b1;                 // after edge 1, sampled at edge 2
    @(negedge f_pwm); bus.upd = 1'b0;                 // after edge 2
    tests++; if (bus.ovr !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", bus.ovr); end
    @(negedge f_pwm);                                 // after edge 3
    tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL ovr_early_valid: got %b expected 0", bus.valid); end
    @(negedge f_pwm);                                 // after edge 4
    tests++; if (bus.valid !== 1'b1 || bus.N_con !== 19'sd8000) begin
      fails++; $display("FAIL ovr_first_result: got valid=%b ncon=%0d expected valid=1 ncon=8000", bus.valid, bus.N_con);
    end
    bus.N_ref = 19'sd50; bus.upd = 1'b1;              // sampled at edge 5
    @(negedge f_pwm); bus.upd = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ovr_accept_cycle5: got busy=%b expected 1", bus.busy); end
    nvalid = 0; got = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge f_pwm);
      if (bus.valid) begin nvalid++; got = bus.N_con; end
    end
    tests++; if (nvalid != 1 || got !== 19'sd4000) begin
      fails++; $display("FAIL ovr_second_result: got %0d valids ncon=%0d expected 1 valid ncon=4000", nvalid, got);
    end
    tests++; if (bus.ovr !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", bus.ovr); end
  endtask

  task automatic test_gain_hold;
    int lat;
    do_reset();
    @(negedge f_pwm);
    bus.K_p = 19'sd320; bus.N_ref = 19'sd100; bus.N_fb = '0; bus.upd = 1'b1;
    @(negedge f_pwm);
    bus.upd = 1'b0; bus.K_p = 19'sd4; bus.N_ref = 19'sd5; bus.N_fb = 19'sd3;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge f_pwm);
      if (bus.valid) begin lat = c; break; end
    end
    tests++; if (lat != 4 || bus.N_con !== 19'sd8000) begin
      fails++; $display("FAIL gain_hold: got lat=%0d ncon=%0d expected lat=4 ncon=8000", lat, bus.N_con);
    end
  endtask

  task automatic test_reset_midop;
    int lat, nvalid; logic signed [W-1:0] con; logic s, bk, be;
    do_reset();
    issue_upd(10, 0, 0, 4, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd10) begin fails++; $display("FAIL midrst_pre: got %0d expected 10", con); end
    @(negedge f_pwm);
    bus.upd = 1'b1;
    @(negedge f_pwm); bus.upd = 1'b0;                 // PROP
    @(negedge f_pwm);                                 // INTEG
    rst = 1'b0;
    #1;
    tests++; if (bus.N_con !== 19'sd0) begin fails++; $display("FAIL midrst_ncon: got %0d expected 0", bus.N_con); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    nvalid = 0;
    repeat (2) begin @(negedge f_pwm); if (bus.valid) nvalid++; end
    rst = 1'b1;
    repeat (8) begin @(negedge f_pwm); if (bus.valid) nvalid++; end
    tests++; if (nvalid != 0) begin fails++; $display("FAIL midrst_no_valid: got %0d valids expected 0", nvalid); end
    issue_upd(10, 0, 0, 4, 0, 1'b0, lat, con, s, bk, be);
    tests++; if (con !== 19'sd10 || lat != 4) begin
      fails++; $display("FAIL midrst_after: got ncon=%0d lat=%0d expected ncon=10 lat=4", con, lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.upd = 1'b0; bus.clr_int = 1'b0;
    bus.N_ref = '0; bus.N_fb = '0; bus.K_p = '0; bus.K_i = '0; bus.K_d = '0;
    test_reset();
    test_proportional();
    test_saturation();
    test_integral();
    test_derivative();
    test_overrun();
    test_gain_hold();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
